hid_zx_matrix_scan: RTL and testbench
=====================================

Name: hid_zx_matrix_scan

Overview:
- Sequential successor to the combinational HID-to-ZX keyboard mapper.
- Snapshots a USB HID boot-keyboard report with NUM_KEYS usage slots plus a modifier byte, then walks the slots one per clock through a translation table.
- Builds a 40-key ZX matrix in a shadow register and commits it atomically; supports two-key combos (cursor keys, backspace, escape).
- Drives the ZX half-row data bus from the committed matrix and A[15:8]; sits between the MCU HID receiver and the port #FE read path.

Parameters:
- NUM_KEYS, 6: number of 8-bit usage slots in the report, range 1..14.
- HOLD_CYCLES, 65536: minimum clk cycles a committed key stays pressed; used only with ZX_KEY_HOLD_EN.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- kb_status  in  8  HID modifier byte. Bit0 LCtrl, bit1 LShift, bit4 RCtrl, bit5 RShift; other bits are ignored.
- kb_report  in  8*NUM_KEYS  usage slots; slot i is bits [8i+7:8i].
- kb_report_upd  in  1  one-cycle strobe: report and status are valid this cycle.
- a  in  8  CPU address A[15:8]; half-row select, active low.
- kb_do  out  6  bits[4:0] = ZX column data (active low); bit5 is constant 1.
- busy  out  1  high while a scan is in progress.
- rollover_err  out  1  one-cycle pulse when a report is rejected.

Behaviour:
- Reset values:
  - Committed matrix, shadow matrix, snapshot and pending flag are all 0.
  - busy=0, rollover_err=0, FSM in IDLE.
  - kb_do=6'h3F for any value of a.
- kb_do is combinational from the committed matrix and a. Column c is pulled low if any selected half-row (a[r]=0) has key (r,c) pressed.
  - Half-row order for a[8]..a[15]: CS-A-Q-1-0-P-ENT-SP style, standard ZX layout.
  - Multiple low address bits OR their rows together.
- FSM states and transitions:
  - IDLE: on kb_report_upd, latch kb_report and kb_status into the snapshot, clear shadow, idx=0, go to SCAN.
  - SCAN: each cycle translate snapshot slot idx and OR its 1-2 ZX keys into shadow. idx increments; after idx=NUM_KEYS-1 go to COMMIT.
  - COMMIT: OR the modifier keys into shadow, copy shadow to the committed matrix, then return to IDLE (or restart, see below).
- Latency: strobe in cycle 0; the new matrix is visible on kb_do in cycle NUM_KEYS+2.
- busy is high from cycle 1 through the COMMIT cycle inclusive.
- Translation table (HID usage -> ZX keys):
  - 0x04-0x1D: A-Z.
  - 0x1E-0x26: 1-9; 0x27: 0.
  - 0x28: ENT; 0x2C: SP.
  - 0x2A: CS+0; 0x29: CS+SP.
  - 0x50: CS+5; 0x51: CS+6; 0x52: CS+7; 0x4F: CS+8.
  - 0x00 and all other codes: no key.
- Modifier mapping: LShift or RShift -> CS; LCtrl or RCtrl -> SS.
- Rollover rejection: if any slot equals 0x01 during SCAN, abort to IDLE without commit.
  - Committed matrix is unchanged.
  - rollover_err pulses in the cycle after detection.
- Strobe while busy: set the pending flag; further strobes are coalesced into it.
  - When pending is set at COMMIT (or at abort), re-enter SCAN next cycle with a fresh snapshot of the current inputs and clear pending.
  - The snapshot always reflects inputs at restart, not at the strobe.
- Strobe in the same cycle as COMMIT: treated as pending.
- Duplicate usages in a report: harmless; OR semantics.
- All slots 0x00 with kb_status=0: commit releases all keys.
- Reset asserted mid-scan: immediate return to the reset state; any partial shadow is lost.

Optional Feature:
- Macro ZX_KEY_HOLD_EN.
- Defined:
  - Each of the 40 keys gets a hold flag, plus a shared free-running counter that pulses every HOLD_CYCLES cycles.
  - A key that goes from pressed to released at COMMIT stays asserted in the effective matrix until the second hold tick after its press commit, giving a minimum hold of HOLD_CYCLES to 2*HOLD_CYCLES.
  - kb_do uses the effective matrix; reset clears all hold flags.
- Undefined: no hold logic; kb_do reflects the committed matrix directly.

Test Plan:
- Reset, then a=8'h00 -> kb_do=6'h3F and busy=0.
- Report slot0=0x04 (A), others 0, strobe:
  - a=8'hFD -> kb_do=6'h3E exactly at cycle NUM_KEYS+2, and not before.
  - busy high for NUM_KEYS+1 cycles.
- Slot0=0x52 (Up):
  - a=8'hFE -> kb_do[0]=0 (CS).
  - a=8'hEF -> kb_do=6'h37 (key 7).
- Report with A committed, then slot2=0x01 strobe:
  - rollover_err pulses once.
  - a=8'hFD still gives 6'h3E.
- Strobe with 0x04, then two more strobes during SCAN with slot0=0x1E (1); inputs held:
  - Exactly one restart occurs.
  - Final a=8'hF7 -> kb_do=6'h3E; A is released.
- kb_status=8'h21 (LCtrl+RShift) with empty slots, and a=8'h7E -> kb_do=6'h3C (CS on col0 and SS on col1 both low).

Source files
------------

// File: rtl/hid_zx_matrix_scan_if.sv
// Bus between the MCU HID receiver side and the ZX keyboard scanner:
// report/status in, ZX half-row data and scanner status out.
interface hid_zx_matrix_scan_if #(
  parameter int NUM_KEYS = 6
);
  logic [7:0]            kb_status;
  logic [8*NUM_KEYS-1:0] kb_report;
  logic                  kb_report_upd;
  logic [7:0]            a;
  logic [5:0]            kb_do;
  logic                  busy;
  logic                  rollover_err;

  modport master (
    output kb_status, kb_report, kb_report_upd, a,
    input  kb_do, busy, rollover_err
  );

  modport slave (
    input  kb_status, kb_report, kb_report_upd, a,
    output kb_do, busy, rollover_err
  );
endinterface

// File: rtl/hid_zx_matrix_scan.sv
// Sequential HID boot-report to ZX Spectrum 8x5 matrix translator.
// Optional key hold-stretching is enabled with `define ZX_KEY_HOLD_EN.
module hid_zx_matrix_scan #(
  parameter int NUM_KEYS    = 6,
  parameter int HOLD_CYCLES = 65536
) (
  input  logic                 clk,
  input  logic                 reset,
  hid_zx_matrix_scan_if.slave  bus
);
  localparam int IW = (NUM_KEYS > 1) ? $clog2(NUM_KEYS) : 1;

  // Matrix bit index is row*5+col; row r is selected by a[r] (A8..A15).
  localparam int K_CS  = 0;
  localparam int K_ENT = 30;
  localparam int K_SP  = 35;
  localparam int K_SS  = 36;
  localparam logic [5:0] LETTER_KEY [26] = '{
    6'd5,  6'd39, 6'd3,  6'd7,  6'd12, 6'd8,  6'd9,  6'd34, 6'd27,
    6'd33, 6'd32, 6'd31, 6'd37, 6'd38, 6'd26, 6'd25, 6'd10, 6'd13,
    6'd6,  6'd14, 6'd28, 6'd4,  6'd11, 6'd2,  6'd29, 6'd1};
  // Usages 0x1E..0x27 are digits 1..9 then 0.
  localparam logic [5:0] DIGIT_KEY [10] = '{
    6'd15, 6'd16, 6'd17, 6'd18, 6'd19, 6'd24, 6'd23, 6'd22, 6'd21, 6'd20};

  if (NUM_KEYS < 1 || NUM_KEYS > 14) begin : g_bad_num_keys
    $error("NUM_KEYS out of range");
  end
  if (HOLD_CYCLES < 1) begin : g_bad_hold
    $error("HOLD_CYCLES must be positive");
  end

  function automatic logic [39:0] translate(input logic [7:0] u);
    logic [39:0] m;
    m = '0;
    if (u >= 8'h04 && u <= 8'h1D) begin
      m[LETTER_KEY[5'(u - 8'h04)]] = 1'b1;
    end else if (u >= 8'h1E && u <= 8'h27) begin
      m[DIGIT_KEY[4'(u - 8'h1E)]] = 1'b1;
    end else begin
      case (u)
        8'h28: m[K_ENT] = 1'b1;
        8'h2C: m[K_SP]  = 1'b1;
        8'h2A: begin m[K_CS] = 1'b1; m[20] = 1'b1; end
        8'h29: begin m[K_CS] = 1'b1; m[K_SP] = 1'b1; end
        8'h50: begin m[K_CS] = 1'b1; m[19] = 1'b1; end
        8'h51: begin m[K_CS] = 1'b1; m[24] = 1'b1; end
        8'h52: begin m[K_CS] = 1'b1; m[23] = 1'b1; end
        8'h4F: begin m[K_CS] = 1'b1; m[22] = 1'b1; end
        default: m = '0;
      endcase
    end
    return m;
  endfunction

  typedef enum logic [1:0] {IDLE, SCAN, COMMIT} state_t;

  state_t                state_reg, state_next;
  logic [IW-1:0]         idx_reg, idx_next;
  logic [39:0]           shadow_reg, shadow_next;
  logic [39:0]           matrix_reg, matrix_next;
  logic [8*NUM_KEYS-1:0] snap_report_reg, snap_report_next;
  logic [1:0]            snap_mod_reg, snap_mod_next;   // {ctrl, shift}
  logic                  pending_reg, pending_next;
  logic                  err_reg, err_next;
  logic                  load;
  logic [7:0]            slot [2**IW];
  logic [7:0]            cur_slot;
  logic [39:0]           mod_keys;
  logic [39:0]           eff_matrix;
  logic [4:0]            col;

  genvar gi;
  generate
    for (gi = 0; gi < 2**IW; gi++) begin : g_slot
      if (gi < NUM_KEYS) begin : g_used
        assign slot[gi] = snap_report_reg[8*gi +: 8];
      end else begin : g_pad
        assign slot[gi] = 8'h00;
      end
    end
  endgenerate

  assign cur_slot = slot[idx_reg];

  always_comb begin
    mod_keys       = '0;
    mod_keys[K_CS] = snap_mod_reg[0];
    mod_keys[K_SS] = snap_mod_reg[1];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg       <= IDLE;
      idx_reg         <= '0;
      shadow_reg      <= '0;
      matrix_reg      <= '0;
      snap_report_reg <= '0;
      snap_mod_reg    <= '0;
      pending_reg     <= 1'b0;
      err_reg         <= 1'b0;
    end else begin
      state_reg       <= state_next;
      idx_reg         <= idx_next;
      shadow_reg      <= shadow_next;
      matrix_reg      <= matrix_next;
      snap_report_reg <= snap_report_next;
      snap_mod_reg    <= snap_mod_next;
      pending_reg     <= pending_next;
      err_reg         <= err_next;
    end
  end

  always_comb begin
    state_next       = state_reg;
    idx_next         = idx_reg;
    shadow_next      = shadow_reg;
    matrix_next      = matrix_reg;
    snap_report_next = snap_report_reg;
    snap_mod_next    = snap_mod_reg;
    pending_next     = pending_reg;
    err_next         = 1'b0;
    load             = 1'b0;
    case (state_reg)
      IDLE: load = bus.kb_report_upd;
      SCAN: begin
        pending_next = pending_reg | bus.kb_report_upd;
        if (cur_slot == 8'h01) begin
          err_next = 1'b1;
          if (pending_reg | bus.kb_report_upd) load = 1'b1;
          else                                 state_next = IDLE;
        end else begin
          shadow_next = shadow_reg | translate(cur_slot);
          if (idx_reg == IW'(NUM_KEYS - 1)) state_next = COMMIT;
          else                              idx_next = idx_reg + 1'b1;
        end
      end
      COMMIT: begin
        matrix_next = shadow_reg | mod_keys;
        if (pending_reg | bus.kb_report_upd) load = 1'b1;
        else                                 state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
    // Restart always samples the live inputs, not those seen at the strobe.
    if (load) begin
      snap_report_next = bus.kb_report;
      snap_mod_next    = {bus.kb_status[0] | bus.kb_status[4],
                          bus.kb_status[1] | bus.kb_status[5]};
      shadow_next      = '0;
      idx_next         = '0;
      pending_next     = 1'b0;
      state_next       = SCAN;
    end
  end

`ifdef ZX_KEY_HOLD_EN
  localparam int CW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  logic [CW-1:0] tick_cnt_reg;
  logic          tick;
  logic          commit;
  logic [39:0]   hold_reg;
  logic [39:0]   tick_seen_reg;

  assign tick   = (tick_cnt_reg == CW'(HOLD_CYCLES - 1));
  assign commit = (state_reg == COMMIT);

  always_ff @(posedge clk or posedge reset) begin
    if (reset)     tick_cnt_reg <= '0;
    else if (tick) tick_cnt_reg <= '0;
    else           tick_cnt_reg <= tick_cnt_reg + 1'b1;
  end

  // A fresh press arms the hold; it expires on the second tick that follows.
  generate
    for (gi = 0; gi < 40; gi++) begin : g_hold
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          hold_reg[gi]      <= 1'b0;
          tick_seen_reg[gi] <= 1'b0;
        end else if (commit && matrix_next[gi] && !matrix_reg[gi]) begin
          hold_reg[gi]      <= 1'b1;
          tick_seen_reg[gi] <= 1'b0;
        end else if (tick && hold_reg[gi]) begin
          if (tick_seen_reg[gi]) hold_reg[gi] <= 1'b0;
          tick_seen_reg[gi] <= 1'b1;
        end
      end
    end
  endgenerate

  assign eff_matrix = matrix_reg | hold_reg;
`else
  assign eff_matrix = matrix_reg;
`endif

  always_comb begin
    col = 5'h1F;
    for (int r = 0; r < 8; r++) begin
      for (int c = 0; c < 5; c++) begin
        if (!bus.a[r] && eff_matrix[r*5+c]) col[c] = 1'b0;
      end
    end
  end

  assign bus.kb_do        = {1'b1, col};
  assign bus.busy         = (state_reg != IDLE);
  assign bus.rollover_err = err_reg;
endmodule

// File: tb/tb_hid_zx_matrix_scan.sv
// Scoreboard bench for hid_zx_matrix_scan: a character-level ZX keyboard
// model predicts kb_do per probed half-row address.
module tb_hid_zx_matrix_scan;
  localparam int NK = 6;
  typedef logic [8*NK-1:0] rep_t;
  typedef struct packed {
    logic [7:0] a;
    logic [5:0] exp;
  } sb_t;

  logic clk;
  logic reset;
  int   checks;
  int   failures;
  int   err_cnt;
  int   busy_cnt;
  sb_t  sb[$];
  logic [39:0] model_mat;
  string zx_rows [8] = '{"^ZXCV", "ASDFG", "QWERT", "12345",
                         "09876", "POIUY", "~LKJH", "_$MNB"};

  hid_zx_matrix_scan_if #(.NUM_KEYS(NK)) bus ();

  hid_zx_matrix_scan #(.NUM_KEYS(NK), .HOLD_CYCLES(16)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (bus.rollover_err) err_cnt++;
    if (bus.busy) busy_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [39:0] char_mask(input byte ch);
    logic [39:0] m;
    m = '0;
    if (ch != 8'd0) begin
      for (int r = 0; r < 8; r++)
        for (int c = 0; c < 5; c++)
          if (zx_rows[r].getc(c) == ch) m[r*5+c] = 1'b1;
    end
    return m;
  endfunction

  task automatic usage_chars(input logic [7:0] u, output byte k1, output byte k2);
    k1 = 8'd0;
    k2 = 8'd0;
    if (u >= 8'h04 && u <= 8'h1D) k1 = byte'(8'h41 + u - 8'h04);
    else if (u >= 8'h1E && u <= 8'h26) k1 = byte'(8'h31 + u - 8'h1E);
    else if (u == 8'h27) k1 = "0";
    else if (u == 8'h28) k1 = "~";
    else if (u == 8'h2C) k1 = "_";
    else if (u == 8'h2A) begin k1 = "^"; k2 = "0"; end
    else if (u == 8'h29) begin k1 = "^"; k2 = "_"; end
    else if (u == 8'h50) begin k1 = "^"; k2 = "5"; end
    else if (u == 8'h51) begin k1 = "^"; k2 = "6"; end
    else if (u == 8'h52) begin k1 = "^"; k2 = "7"; end
    else if (u == 8'h4F) begin k1 = "^"; k2 = "8"; end
  endtask

  task automatic model_update(input rep_t rep, input logic [7:0] st);
    logic [39:0] m;
    byte k1, k2;
    logic roll;
    m = '0;
    roll = 1'b0;
    for (int i = 0; i < NK; i++) begin
      if (rep[8*i +: 8] == 8'h01) roll = 1'b1;
      usage_chars(rep[8*i +: 8], k1, k2);
      m |= char_mask(k1) | char_mask(k2);
    end
    if (st[1] || st[5]) m |= char_mask("^");
    if (st[0] || st[4]) m |= char_mask("$");
    if (!roll) model_mat = m;
  endtask

  function automatic logic [5:0] exp_do(input logic [39:0] mat, input logic [7:0] a);
    logic [4:0] col;
    col = 5'h1F;
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 5; c++)
        if (!a[r] && mat[r*5+c]) col[c] = 1'b0;
    return {1'b1, col};
  endfunction

  function automatic rep_t mk(input logic [7:0] s0, input logic [7:0] s1, input logic [7:0] s2);
    rep_t r;
    r = '0;
    r[7:0]   = s0;
    r[15:8]  = s1;
    r[23:16] = s2;
    return r;
  endfunction

  task automatic expect_do(input logic [7:0] a);
    sb.push_back('{a: a, exp: exp_do(model_mat, a)});
  endtask

  // Drives a one-cycle strobe; returns #1 after the edge that sampled it.
  task automatic send(input rep_t rep, input logic [7:0] st);
    @(posedge clk);
    #1;
    bus.kb_report     = rep;
    bus.kb_status     = st;
    bus.kb_report_upd = 1'b1;
    model_update(rep, st);
    @(posedge clk);
    #1;
    bus.kb_report_upd = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (bus.busy && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) check("timeout", 32'd1, 32'd0);
    @(negedge clk);
  endtask

  task automatic drain(input string tag);
    sb_t e;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      @(negedge clk);
      bus.a = e.a;
      #1;
      check(tag, 32'(bus.kb_do), 32'(e.exp));
    end
  endtask

  initial begin
    int early, first_k, blen, snap_err, snap_busy;
    checks = 0;
    failures = 0;
    model_mat = '0;
    reset = 1'b1;
    bus.kb_status = 8'h00;
    bus.kb_report = '0;
    bus.kb_report_upd = 1'b0;
    bus.a = 8'h00;
    repeat (3) @(negedge clk);
    check("reset_kb_do", 32'(bus.kb_do), 32'h3F);
    check("reset_busy", 32'(bus.busy), 32'd0);
    check("reset_err", 32'(bus.rollover_err), 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;

    // Latency: strobe in cycle 0, matrix visible in cycle NK+2.
    bus.a = 8'hFD;
    @(posedge clk);
    #1;
    bus.kb_report = mk(8'h04, 8'h00, 8'h00);
    bus.kb_status = 8'h00;
    bus.kb_report_upd = 1'b1;
    model_update(bus.kb_report, 8'h00);
    expect_do(8'hFD);
    @(posedge clk);
    #1;
    bus.kb_report_upd = 1'b0;
    early = 0;
    first_k = -1;
    blen = 0;
    for (int k = 1; k <= NK + 3; k++) begin
      @(negedge clk);
      if (bus.busy) blen++;
      if (bus.kb_do != 6'h3F && k < NK + 2) early++;
      if (bus.kb_do == 6'h3E && first_k < 0) first_k = k;
    end
    check("lat_early", 32'(early), 32'd0);
    check("lat_cycle", 32'(first_k), 32'(NK + 2));
    check("busy_len", 32'(blen), 32'(NK + 1));
    drain("lat_final");

    send(mk(8'h52, 8'h00, 8'h00), 8'h00);
    expect_do(8'hFE);
    expect_do(8'hEF);
    wait_idle();
    drain("up_combo");

    send(mk(8'h04, 8'h00, 8'h00), 8'h00);
    wait_idle();
    snap_err = err_cnt;
    send(mk(8'h1E, 8'h00, 8'h01), 8'h00);
    expect_do(8'hFD);
    expect_do(8'hF7);
    wait_idle();
    repeat (3) @(negedge clk);
    check("rollover_pulses", 32'(err_cnt - snap_err), 32'd1);
    drain("rollover_keep");

    // Two strobes during SCAN coalesce into a single restart.
    snap_busy = busy_cnt;
    send(mk(8'h04, 8'h00, 8'h00), 8'h00);
    bus.kb_report = mk(8'h1E, 8'h00, 8'h00);
    model_update(bus.kb_report, 8'h00);
    bus.kb_report_upd = 1'b1;
    @(posedge clk);
    #1;
    bus.kb_report_upd = 1'b0;
    @(posedge clk);
    #1;
    bus.kb_report_upd = 1'b1;
    @(posedge clk);
    #1;
    bus.kb_report_upd = 1'b0;
    expect_do(8'hF7);
    expect_do(8'hFD);
    wait_idle();
    check("one_restart", 32'(busy_cnt - snap_busy), 32'(2 * (NK + 1)));
    drain("pending");

    send(mk(8'h00, 8'h00, 8'h00), 8'h00);
    expect_do(8'h00);
    wait_idle();
    drain("release_all");

    send(mk(8'h00, 8'h00, 8'h00), 8'h21);
    expect_do(8'h7E);
    expect_do(8'hFE);
    expect_do(8'h7F);
    wait_idle();
    drain("modifiers");

    send(mk(8'h2A, 8'h04, 8'h04), 8'h00);
    expect_do(8'hEE);
    expect_do(8'hFD);
    expect_do(8'h00);
    wait_idle();
    drain("bksp_dup");

    send(mk(8'h1D, 8'h10, 8'h29), 8'h00);
    expect_do(8'hFE);
    expect_do(8'h7F);
    expect_do(8'hBF);
    wait_idle();
    drain("zm_esc");

    // Reset in the middle of a scan drops everything.
    send(mk(8'h05, 8'h00, 8'h00), 8'h00);
    @(negedge clk);
    reset = 1'b1;
    bus.a = 8'h00;
    #1;
    check("midscan_kb_do", 32'(bus.kb_do), 32'h3F);
    check("midscan_busy", 32'(bus.busy), 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    model_mat = '0;
    expect_do(8'h00);
    repeat (NK + 4) @(negedge clk);
    drain("after_reset");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
